fp16_operand_loader: RTL and testbench
======================================

// Module: fp16_operand_loader
// PURPOSE
//  Upstream stage of the FP16 logarithmic multiplier. Assembles two byte-serial
//  FP16 operands (A on the ui_in byte lane, B on the uio_in byte lane, LSB first)
//  into 16-bit words. Flushes subnormals to signed zero and classifies
//  zero/inf/NaN. Presents the operand pair to the multiplier core over a
//  valid/ready handshake.
// PARAMETERS
//  EXP_W     5   exponent field width
//  MAN_W     10  mantissa field width (EXP_W+MAN_W+1 = 16)
//  TIMEOUT   15  max cycles (ena=1) waiting for the high byte before abort, 1..255
// PORTS
//  clk        in   1   clock, rising edge
//  rst_n      in   1   reset, asynchronous, active-low
//  ena        in   1   stage enable; 0 freezes all state and counters
//  in_valid   in   1   byte pair on in_a_byte/in_b_byte is valid
//  in_a_byte  in   8   operand A byte (from ui_in)
//  in_b_byte  in   8   operand B byte (from uio_in)
//  in_ready   out  1   loader accepts a byte pair this cycle
//  op_valid   out  1   op_a/op_b/op_flags valid for the core
//  op_ready   in   1   core consumes the operand pair
//  op_a       out  16  operand A {S,E,M}, subnormal-flushed
//  op_b       out  16  operand B {S,E,M}, subnormal-flushed
//  op_flags   out  3   [0] any_zero  [1] any_inf  [2] any_nan
//  err_tmo    out  1   one-cycle pulse: frame aborted by timeout
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, in_ready=0, op_valid=0, op_a=op_b=0,
//   op_flags=0, err_tmo=0, timeout counter=0.
//   Asserting reset mid-frame discards all partial data immediately.
//  Accept = in_valid & in_ready. in_ready = ena & (state==IDLE | state==HI).
//   It is combinational from registered state only.
//  FSM:
//   IDLE: on accept, latch low bytes A[7:0], B[7:0]; clear counter; -> HI.
//   HI: on accept, latch high bytes A[15:8], B[15:8]; -> HOLD. Next cycle:
//    op_valid=1 with final op_a/op_b/op_flags (1-cycle latency from the
//    high-byte accept).
//    Without accept and ena=1, counter++. When the counter reaches TIMEOUT,
//    err_tmo=1 for one cycle, drop partial bytes, -> IDLE.
//   HOLD: op_valid=1. op_a/op_b/op_flags are held stable until op_valid &
//    op_ready; then op_valid=0 next cycle and -> IDLE. in_ready=0 throughout.
//  ena=0 in any state: no accept, counter frozen, outputs held, no state change.
//   A pending op_ready handshake in HOLD still completes, because the core
//   runs independently.
//  Word assembly/flush (registered at HI->HOLD), per operand X:
//   E=X[14:10], M=X[9:0]. If E==0, output {S,5'b0,10'b0}; otherwise pass through.
//   zero_X = (E==0); inf_X = (E==31 & M==0); nan_X = (E==31 & M!=0).
//  Flags:
//   any_nan  = nan_a | nan_b | (inf_a & zero_b) | (inf_b & zero_a)
//   any_inf  = (inf_a | inf_b) & ~any_nan
//   any_zero = (zero_a | zero_b) & ~any_nan
//   At most one of any_inf/any_zero is set unless any_nan=1.
//  Simultaneous: a new low byte is never accepted in the HOLD->IDLE cycle. The
//   first new accept happens the cycle after IDLE is entered.
//  Back-to-back frames: sustained throughput is 1 operand pair per 3 cycles when
//   op_ready is held high.
//  in_valid with ena=1 in HOLD is ignored; the source must hold its byte.
// TESTING
//  1 Bytes (A,B)=(0x00,0x00) then (0x3C,0x40), op_ready=1 -> op_valid 1 cycle
//    after the 2nd accept; op_a=0x3C00, op_b=0x4000, op_flags=0.
//  2 A=0x8001 (subnormal), B=0x4500 -> op_a=0x8000, op_b=0x4500, op_flags=3'b001.
//  3 A=0x7C00 (inf), B=0x0000 -> op_flags=3'b100. A=0x7C00, B=0x3C00 -> 3'b010.
//    A=0x7E00 -> 3'b100.
//  4 Low byte accepted, then in_valid=0 for 15 cycles -> err_tmo pulses on the
//    15th, state=IDLE. The next pair is treated as a low byte.
//  5 op_ready=0 for 10 cycles in HOLD while in_valid=1 -> in_ready=0, op_a
//    stable. Raise op_ready -> op_valid drops next cycle, next frame accepted
//    the cycle after.
//  6 rst_n pulsed low asynchronously while in HI -> outputs zero immediately. A
//    subsequent full frame loads correctly.

Source files
------------

// File: rtl/fp16_operand_loader.sv
`default_nettype none
// ============================================================================
//  Module      : fp16_operand_loader
//  Description : Input stage of the FP16 logarithmic multiplier. Collects two
//                byte-serial FP16 operands (A on in_a_byte, B on in_b_byte,
//                low byte first), flushes subnormals to signed zero,
//                classifies zero/inf/NaN for the pair and hands the result to
//                the multiplier core over a valid/ready handshake.
//  Ports       : clk, rst_n      clock (rising edge), async active-low reset
//                ena             stage enable; 0 freezes state and counter
//                in_valid/in_ready, in_a_byte/in_b_byte   byte-pair input
//                op_valid/op_ready, op_a/op_b, op_flags   operand-pair output
//                                op_flags = {any_nan, any_inf, any_zero}
//                err_tmo         one-cycle pulse when a frame is abandoned
//                                while waiting for its high byte
//  Revision    : 1.0  initial release
// ============================================================================
module fp16_operand_loader #(
    parameter int EXP_W   = 5,
    parameter int MAN_W   = 10,
    parameter int TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    input  logic                   in_valid,
    input  logic [7:0]             in_a_byte,
    input  logic [7:0]             in_b_byte,
    output logic                   in_ready,
    output logic                   op_valid,
    input  logic                   op_ready,
    output logic [EXP_W+MAN_W:0]   op_a,
    output logic [EXP_W+MAN_W:0]   op_b,
    output logic [2:0]             op_flags,
    output logic                   err_tmo
);

    localparam int         c_W        = 1 + EXP_W + MAN_W;
    localparam logic [7:0] c_TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HI   = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;
    logic       w_tmo_fire;
    logic       w_accept;

    logic [7:0]     r_lo_a;
    logic [7:0]     r_lo_b;
    logic [c_W-1:0] r_op_a;
    logic [c_W-1:0] r_op_b;
    logic [2:0]     r_flags;
    logic           r_err_tmo;

    // ------------------------------------------------------------------------
    // Handshake. in_ready depends only on registered state (plus ena), so the
    // source never sees a combinational path from its own in_valid. It is
    // also held low while reset is asserted.
    // ------------------------------------------------------------------------
    assign in_ready = ena & rst_n & ((r_state == S_IDLE) | (r_state == S_HI));
    assign w_accept = in_valid & in_ready;
    assign op_valid = (r_state == S_HOLD);

    // ------------------------------------------------------------------------
    // FSM: state and timeout counter registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state, counter and timeout strobe
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_tmo_fire  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_HI;
                    w_cnt_nxt   = 8'd0;
                end
            end
            S_HI: begin
                if (w_accept) begin
                    w_state_nxt = S_HOLD;
                    w_cnt_nxt   = 8'd0;
                end else if (ena) begin
                    // The counter is compared before incrementing, so the
                    // abort lands on the TIMEOUT-th waiting cycle.
                    if (r_cnt == c_TMO_LAST) begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = 8'd0;
                        w_tmo_fire  = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end
            end
            S_HOLD: begin
                // The core runs independently of ena, so the handshake
                // completes even while this stage is disabled.
                if (op_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 8'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Word assembly, subnormal flush and per-operand classification. The high
    // byte comes straight from the input lane so the final word is registered
    // on the same edge that accepts it.
    // ------------------------------------------------------------------------
    logic [c_W-1:0] w_raw  [2];
    logic [c_W-1:0] w_word [2];
    logic [1:0]     w_zero;
    logic [1:0]     w_inf;
    logic [1:0]     w_nan;

    assign w_raw[0] = c_W'({in_a_byte, r_lo_a});
    assign w_raw[1] = c_W'({in_b_byte, r_lo_b});

    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_op
        logic             w_sign;
        logic [EXP_W-1:0] w_exp;
        logic [MAN_W-1:0] w_man;

        assign w_sign = w_raw[gi][c_W-1];
        assign w_exp  = w_raw[gi][c_W-2 -: EXP_W];
        assign w_man  = w_raw[gi][MAN_W-1:0];

        // Exponent zero covers both true zero and subnormals; both become
        // signed zero and count as zero for classification.
        assign w_zero[gi] = (w_exp == '0);
        assign w_inf[gi]  = (&w_exp) & ~(|w_man);
        assign w_nan[gi]  = (&w_exp) &  (|w_man);

        assign w_word[gi] = w_zero[gi] ? {w_sign, {(c_W-1){1'b0}}} : w_raw[gi];
    end

    logic w_any_nan;
    logic w_any_inf;
    logic w_any_zero;

    // inf * 0 is invalid and reported as NaN; NaN masks the other flags.
    assign w_any_nan  = (|w_nan) | (w_inf[0] & w_zero[1]) | (w_inf[1] & w_zero[0]);
    assign w_any_inf  = (|w_inf)  & ~w_any_nan;
    assign w_any_zero = (|w_zero) & ~w_any_nan;

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lo_a    <= 8'd0;
            r_lo_b    <= 8'd0;
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_flags   <= 3'd0;
            r_err_tmo <= 1'b0;
        end else begin
            r_err_tmo <= w_tmo_fire;
            if (w_accept && (r_state == S_IDLE)) begin
                r_lo_a <= in_a_byte;
                r_lo_b <= in_b_byte;
            end else if (w_tmo_fire) begin
                r_lo_a <= 8'd0;
                r_lo_b <= 8'd0;
            end
            if (w_accept && (r_state == S_HI)) begin
                r_op_a  <= w_word[0];
                r_op_b  <= w_word[1];
                r_flags <= {w_any_nan, w_any_inf, w_any_zero};
            end
        end
    end

    assign op_a     = r_op_a;
    assign op_b     = r_op_b;
    assign op_flags = r_flags;
    assign err_tmo  = r_err_tmo;

endmodule
`default_nettype wire

// File: tb/tb_fp16_operand_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp16_operand_loader
//  Description : Directed self-checking bench for fp16_operand_loader.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fp16_operand_loader;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic        in_valid;
    logic [7:0]  in_a_byte;
    logic [7:0]  in_b_byte;
    logic        in_ready;
    logic        op_valid;
    logic        op_ready;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [2:0]  op_flags;
    logic        err_tmo;

    int errors = 0;
    int checks = 0;

    fp16_operand_loader #(
        .EXP_W   (5),
        .MAN_W   (10),
        .TIMEOUT (15)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .in_valid  (in_valid),
        .in_a_byte (in_a_byte),
        .in_b_byte (in_b_byte),
        .in_ready  (in_ready),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_flags  (op_flags),
        .err_tmo   (err_tmo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    // Advance one clock; inputs are then changed / outputs sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present low then high byte pair from IDLE; returns with DUT in HOLD.
    task automatic drive_frame(input logic [15:0] a, input logic [15:0] b);
        in_valid  = 1'b1;
        in_a_byte = a[7:0];
        in_b_byte = b[7:0];
        tick();
        in_a_byte = a[15:8];
        in_b_byte = b[15:8];
        tick();
        in_valid  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0; op_ready = 1'b1;
        in_a_byte = 8'h00; in_b_byte = 8'h00;
        #3;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
        checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL rst_op_valid: got %b expected 0", op_valid); end
        checks++; if (op_a !== 16'h0000 || op_b !== 16'h0000) begin errors++; $display("FAIL rst_ops: got %h/%h expected 0000/0000", op_a, op_b); end
        checks++; if (op_flags !== 3'b000 || err_tmo !== 1'b0) begin errors++; $display("FAIL rst_flags: got %b/%b expected 000/0", op_flags, err_tmo); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_basic();
        op_ready = 1'b1;
        in_valid = 1'b1; in_a_byte = 8'h00; in_b_byte = 8'h00;
        tick();
        checks++; if (in_ready !== 1'b1 || op_valid !== 1'b0) begin errors++; $display("FAIL basic_hi: got ready=%b valid=%b expected 1/0", in_ready, op_valid); end
        in_a_byte = 8'h3C; in_b_byte = 8'h40;
        tick();
        in_valid = 1'b0;
        checks++; if (op_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL basic_hold: got valid=%b ready=%b expected 1/0", op_valid, in_ready); end
        checks++; if (op_a !== 16'h3C00 || op_b !== 16'h4000) begin errors++; $display("FAIL basic_ops: got %h/%h expected 3c00/4000", op_a, op_b); end
        checks++; if (op_flags !== 3'b000) begin errors++; $display("FAIL basic_flags: got %b expected 000", op_flags); end
        tick();
        checks++; if (op_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL basic_done: got valid=%b ready=%b expected 0/1", op_valid, in_ready); end
    endtask

    task automatic test_flush();
        drive_frame(16'h8001, 16'h4500);
        checks++; if (op_a !== 16'h8000 || op_b !== 16'h4500) begin errors++; $display("FAIL flush_ops: got %h/%h expected 8000/4500", op_a, op_b); end
        checks++; if (op_flags !== 3'b001) begin errors++; $display("FAIL flush_flags: got %b expected 001", op_flags); end
        tick();
        // Largest subnormal vs. smallest normal
        drive_frame(16'h03FF, 16'h0400);
        checks++; if (op_a !== 16'h0000 || op_b !== 16'h0400) begin errors++; $display("FAIL flush_edge_ops: got %h/%h expected 0000/0400", op_a, op_b); end
        checks++; if (op_flags !== 3'b001) begin errors++; $display("FAIL flush_edge_flags: got %b expected 001", op_flags); end
        tick();
        // Max normal on both sides, negative B
        drive_frame(16'h7BFF, 16'hFBFF);
        checks++; if (op_a !== 16'h7BFF || op_b !== 16'hFBFF || op_flags !== 3'b000) begin errors++; $display("FAIL maxnorm: got %h/%h/%b expected 7bff/fbff/000", op_a, op_b, op_flags); end
        tick();
    endtask

    task automatic test_special();
        drive_frame(16'h7C00, 16'h0000);
        checks++; if (op_flags !== 3'b100) begin errors++; $display("FAIL inf_x_zero: got %b expected 100", op_flags); end
        tick();
        drive_frame(16'h7C00, 16'h3C00);
        checks++; if (op_flags !== 3'b010 || op_a !== 16'h7C00) begin errors++; $display("FAIL inf_x_one: got %b/%h expected 010/7c00", op_flags, op_a); end
        tick();
        drive_frame(16'h7E00, 16'h3C00);
        checks++; if (op_flags !== 3'b100) begin errors++; $display("FAIL nan_a: got %b expected 100", op_flags); end
        tick();
        // Subnormal B flushed to -0 counts as zero against -inf A
        drive_frame(16'hFC00, 16'h8200);
        checks++; if (op_b !== 16'h8000 || op_flags !== 3'b100) begin errors++; $display("FAIL ninf_x_sub: got %h/%b expected 8000/100", op_b, op_flags); end
        tick();
        drive_frame(16'h3C00, 16'hFC00);
        checks++; if (op_flags !== 3'b010) begin errors++; $display("FAIL inf_b: got %b expected 010", op_flags); end
        tick();
    endtask

    task automatic test_timeout();
        logic seen;
        in_valid = 1'b1; in_a_byte = 8'h11; in_b_byte = 8'h22;
        tick();
        in_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (err_tmo !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL tmo_early: got err_seen=%b ready=%b expected 0/1", seen, in_ready); end
        tick();
        checks++; if (err_tmo !== 1'b1) begin errors++; $display("FAIL tmo_pulse: got %b expected 1", err_tmo); end
        tick();
        checks++; if (err_tmo !== 1'b0) begin errors++; $display("FAIL tmo_width: got %b expected 0", err_tmo); end
        drive_frame(16'h3C00, 16'h4000);
        checks++; if (op_valid !== 1'b1 || op_a !== 16'h3C00 || op_b !== 16'h4000) begin errors++; $display("FAIL tmo_next: got %b %h/%h expected 1 3c00/4000", op_valid, op_a, op_b); end
        tick();
    endtask

    task automatic test_ena_freeze();
        logic seen;
        in_valid = 1'b1; in_a_byte = 8'h01; in_b_byte = 8'h02;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        ena = 1'b0;
        in_valid = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (err_tmo !== 1'b0 || in_ready !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL ena_freeze: got activity=%b expected 0", seen); end
        in_valid = 1'b0;
        ena = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (err_tmo !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL ena_cnt_held: got err_seen=%b expected 0", seen); end
        tick();
        checks++; if (err_tmo !== 1'b1) begin errors++; $display("FAIL ena_tmo_pulse: got %b expected 1", err_tmo); end
        tick();
        // Handshake in HOLD completes with ena low
        drive_frame(16'h4000, 16'h4000);
        ena = 1'b0;
        tick();
        checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL ena_hold_hs: got %b expected 0", op_valid); end
        ena = 1'b1;
    endtask

    task automatic test_hold_stall();
        logic bad;
        op_ready = 1'b0;
        drive_frame(16'h4248, 16'hC500);
        in_valid = 1'b1; in_a_byte = 8'hAA; in_b_byte = 8'hBB;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (in_ready !== 1'b0 || op_valid !== 1'b1 || op_a !== 16'h4248 || op_b !== 16'hC500) bad = 1'b1;
        end
        checks++; if (bad !== 1'b0) begin errors++; $display("FAIL stall_hold: got disturbed=%b expected 0", bad); end
        op_ready = 1'b1;
        tick();
        checks++; if (op_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL stall_release: got valid=%b ready=%b expected 0/1", op_valid, in_ready); end
        tick();
        in_a_byte = 8'h3C; in_b_byte = 8'h40;
        tick();
        in_valid = 1'b0;
        checks++; if (op_valid !== 1'b1 || op_a !== 16'h3CAA || op_b !== 16'h40BB) begin errors++; $display("FAIL stall_next: got %b %h/%h expected 1 3caa/40bb", op_valid, op_a, op_b); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [15:0] va [3];
        int          nvalid;
        va[0] = 16'h3C00; va[1] = 16'hC000; va[2] = 16'h4400;
        op_ready = 1'b1;
        nvalid = 0;
        for (int f = 0; f < 3; f++) begin
            drive_frame(va[f], 16'h3C00);
            if (op_valid === 1'b1 && op_a === va[f]) nvalid++;
            tick();
            if (op_valid === 1'b1) nvalid = nvalid + 100;
        end
        checks++; if (nvalid !== 3) begin errors++; $display("FAIL b2b_rate: got score %0d expected 3", nvalid); end
    endtask

    task automatic test_async_reset();
        in_valid = 1'b1; in_a_byte = 8'h99; in_b_byte = 8'h77;
        tick();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (op_a !== 16'h0000 || op_flags !== 3'b000 || in_ready !== 1'b0) begin errors++; $display("FAIL arst_now: got %h/%b/%b expected 0000/000/0", op_a, op_flags, in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        drive_frame(16'h5555, 16'h2AAA);
        checks++; if (op_a !== 16'h5555 || op_b !== 16'h2AAA || op_flags !== 3'b000) begin errors++; $display("FAIL arst_reload: got %h/%h/%b expected 5555/2aaa/000", op_a, op_b, op_flags); end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_flush();
        test_special();
        test_timeout();
        test_ena_freeze();
        test_hold_stall();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
